// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO pointer defaults and Gray/binary conversion helpers
package fifo_pkg;
  localparam int unsigned PTR_WIDTH_DEF = 3;
  // Callers zero-extend narrower pointers; the results stay correct at any width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_sync.sv
// gray_sync: multi-flop synchroniser chain for a Gray-coded pointer
module gray_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             rclock,
  input  logic             rreset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [STAGES-1:0][WIDTH-1:0] r_sync;
  // Shift the pointer through the chain; the oldest stage is the synchronised value.
  always_ff @(posedge rclock)
    if (!rreset) r_sync <= '0;
    else r_sync <= {r_sync[STAGES-2:0], i_d};
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/read_pointer.sv
// read_pointer: async FIFO read-domain pointers and flags; READ_POINTER_UNDERFLOW_EN adds a sticky underflow flag
module read_pointer
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_WIDTH   = PTR_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 1
) (
  input  logic               rclock,
  input  logic               rreset,
  input  logic               r_en,
  input  logic [PTR_WIDTH:0] gray_wptr,
  output logic [PTR_WIDTH:0] bin_rptr,
  output logic [PTR_WIDTH:0] gray_rptr,
  output logic               empty,
  output logic               almost_empty,
  output logic [PTR_WIDTH:0] rd_count
`ifdef READ_POINTER_UNDERFLOW_EN
  ,
  output logic               underflow
`endif
);
  localparam int unsigned W = PTR_WIDTH + 1;
  logic [PTR_WIDTH:0] r_bin_rptr, r_gray_rptr, r_rd_count;
  logic               r_empty, r_almost_empty;
  logic [PTR_WIDTH:0] w_wptr_sync, w_bin_next, w_gray_next, w_count_next;
  logic               w_rd_inc;
  gray_sync #(.WIDTH(W), .STAGES(SYNC_STAGES)) u_wsync (
    .rclock (rclock),
    .rreset (rreset),
    .i_d    (gray_wptr),
    .o_q    (w_wptr_sync)
  );
  // Next pointer state; occupancy is computed against the advanced pointer so the last read flags empty at once.
  always_comb begin
    w_rd_inc     = r_en & ~r_empty;
    w_bin_next   = r_bin_rptr + W'(w_rd_inc);
    w_gray_next  = W'(bin2gray(32'(w_bin_next)));
    w_count_next = W'(gray2bin(32'(w_wptr_sync))) - w_bin_next;
  end
  // Pointer and flag registers; a read while empty leaves everything unchanged.
  always_ff @(posedge rclock)
    if (!rreset) begin
      r_bin_rptr     <= '0;
      r_gray_rptr    <= '0;
      r_rd_count     <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
    end else begin
      r_bin_rptr     <= w_bin_next;
      r_gray_rptr    <= w_gray_next;
      r_rd_count     <= w_count_next;
      r_empty        <= w_gray_next == w_wptr_sync;
      r_almost_empty <= 32'(w_count_next) <= AE_THRESH;
    end
`ifdef READ_POINTER_UNDERFLOW_EN
  logic r_underflow;
  // Sticky record of any read attempted while empty; only reset clears it.
  always_ff @(posedge rclock)
    if (!rreset) r_underflow <= 1'b0;
    else r_underflow <= r_underflow | (r_en & r_empty);
  assign underflow = r_underflow;
`endif
  assign bin_rptr     = r_bin_rptr;
  assign gray_rptr    = r_gray_rptr;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign rd_count     = r_rd_count;
endmodule

// File: tb/tb_read_pointer.sv
// tb_read_pointer: directed self-checking bench for read_pointer
module tb_read_pointer;
  logic       rclock = 1'b0;
  logic       rreset = 1'b0;
  logic       r_en = 1'b0;
  logic [3:0] gray_wptr = 4'b0000;
  logic [3:0] bin_rptr, gray_rptr, rd_count;
  logic       empty, almost_empty;
`ifdef READ_POINTER_UNDERFLOW_EN
  logic       underflow;
`endif
  int passed = 0;
  int total = 0;
  logic [3:0] gtab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                            4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
  read_pointer dut (
    .rclock       (rclock),
    .rreset       (rreset),
    .r_en         (r_en),
    .gray_wptr    (gray_wptr),
    .bin_rptr     (bin_rptr),
    .gray_rptr    (gray_rptr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count)
`ifdef READ_POINTER_UNDERFLOW_EN
    ,
    .underflow    (underflow)
`endif
  );
  always #5 rclock = ~rclock;
  task automatic tick();
    @(posedge rclock);
    @(negedge rclock);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_bin"}, 32'(bin_rptr), 32'd0);
    chk({tag, "_gray"}, 32'(gray_rptr), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
    chk({tag, "_cnt"}, 32'(rd_count), 32'd0);
`ifdef READ_POINTER_UNDERFLOW_EN
    chk({tag, "_uf"}, 32'(underflow), 32'd0);
`endif
  endtask
  initial begin
    int rp;
    int w;
    rreset = 1'b0;
    r_en = 1'b1;
    tick();
    chk_reset("rst");
    rreset = 1'b1;
    r_en = 1'b0;
    gray_wptr = 4'b0001;
    tick();
    chk("lat_e1_empty", 32'(empty), 32'd1);
    tick();
    chk("lat_e2_empty", 32'(empty), 32'd1);
    chk("lat_e2_cnt", 32'(rd_count), 32'd0);
    tick();
    chk("lat_e3_empty", 32'(empty), 32'd0);
    chk("lat_e3_cnt", 32'(rd_count), 32'd1);
    chk("lat_e3_ae", 32'(almost_empty), 32'd1);
    r_en = 1'b1;
    tick();
    chk("rd1_bin", 32'(bin_rptr), 32'd1);
    chk("rd1_gray", 32'(gray_rptr), 32'd1);
    chk("rd1_empty", 32'(empty), 32'd1);
    chk("rd1_cnt", 32'(rd_count), 32'd0);
    tick();
    chk("uf_bin_hold", 32'(bin_rptr), 32'd1);
    chk("uf_gray_hold", 32'(gray_rptr), 32'd1);
    chk("uf_empty", 32'(empty), 32'd1);
`ifdef READ_POINTER_UNDERFLOW_EN
    chk("uf_flag", 32'(underflow), 32'd1);
    r_en = 1'b0;
    tick();
    chk("uf_sticky", 32'(underflow), 32'd1);
`endif
    r_en = 1'b0;
    rreset = 1'b0;
    gray_wptr = 4'b0000;
    tick();
    chk_reset("rst2");
    rreset = 1'b1;
    gray_wptr = 4'b1100;
    tick();
    tick();
    chk("full_e2_cnt", 32'(rd_count), 32'd0);
    tick();
    chk("full_cnt", 32'(rd_count), 32'd8);
    chk("full_ae", 32'(almost_empty), 32'd0);
    chk("full_empty", 32'(empty), 32'd0);
    r_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("burst%0d_bin", i), 32'(bin_rptr), 32'(i));
      chk($sformatf("burst%0d_gray", i), 32'(gray_rptr), 32'(gtab[i]));
      chk($sformatf("burst%0d_cnt", i), 32'(rd_count), 32'(8 - i));
      chk($sformatf("burst%0d_ae", i), 32'(almost_empty), (8 - i) <= 1 ? 32'd1 : 32'd0);
      chk($sformatf("burst%0d_empty", i), 32'(empty), i == 8 ? 32'd1 : 32'd0);
    end
    tick();
    chk("burst_over_bin", 32'(bin_rptr), 32'd8);
    chk("burst_over_gray", 32'(gray_rptr), 32'd12);
    r_en = 1'b0;
    rp = 8;
    for (int k = 0; k < 16; k++) begin
      w = (rp + 8) % 16;
      gray_wptr = gtab[w];
      tick();
      tick();
      tick();
      chk($sformatf("wrap%0d_full", k), 32'(rd_count), 32'd8);
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      rp = (rp + 1) % 16;
      chk($sformatf("wrap%0d_bin", k), 32'(bin_rptr), 32'(rp));
      chk($sformatf("wrap%0d_gray", k), 32'(gray_rptr), 32'(gtab[rp]));
      chk($sformatf("wrap%0d_cnt", k), 32'(rd_count), 32'd7);
    end
    r_en = 1'b1;
    tick();
    tick();
    chk("mid_cnt", 32'(rd_count), 32'd5);
    chk("mid_bin", 32'(bin_rptr), 32'd10);
    rreset = 1'b0;
    gray_wptr = 4'b0000;
    tick();
    chk_reset("rst_mid");
    rreset = 1'b1;
    r_en = 1'b0;
    gray_wptr = 4'b0001;
    tick();
    tick();
    chk("relat_e2_empty", 32'(empty), 32'd1);
    chk("relat_e2_cnt", 32'(rd_count), 32'd0);
    tick();
    chk("relat_e3_empty", 32'(empty), 32'd0);
    chk("relat_e3_cnt", 32'(rd_count), 32'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
